// File: rtl/bluetooth_tx_framer.sv
// Byte-serial framer: turns one payload word into "AT+BLEUARTTX=" + uppercase hex
// (MSB nibble first) + optional CR LF, streamed over a valid/ready byte interface.
module bluetooth_tx_framer #(
  parameter int DATA_WIDTH  = 32,
  parameter int APPEND_CRLF = 1,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_byte,
  output logic                   out_last,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] frame_count,
  output logic [1:0]             dbg_state
);
  // Handshakes: a transfer happens on a rising edge where valid && ready; a
  // producer holds valid and its data stable until that edge, and ready may
  // depend on state only, never combinationally on valid.

  localparam int NIBBLES    = DATA_WIDTH / 4;
  localparam int PREFIX_LEN = 13;

  if ((DATA_WIDTH % 4) != 0 || DATA_WIDTH < 4 || DATA_WIDTH > 64) begin : g_bad_width
    $fatal(1, "bluetooth_tx_framer: DATA_WIDTH must be a multiple of 4 in 4..64");
  end
  if (APPEND_CRLF != 0 && APPEND_CRLF != 1) begin : g_bad_crlf
    $fatal(1, "bluetooth_tx_framer: APPEND_CRLF must be 0 or 1");
  end

  typedef enum logic [1:0] {IDLE, PREFIX, PAYLOAD, TERM} state_t;

  state_t                  state, state_n;
  logic [4:0]              idx, idx_n;
  logic [DATA_WIDTH-1:0]   data_q, data_n;
  logic [7:0]              byte_n;
  logic                    last_n;
  logic                    handshake;

  function automatic logic [7:0] prefix_char(input logic [4:0] i);
    case (i)
      5'd0:    prefix_char = 8'h41;
      5'd1:    prefix_char = 8'h54;
      5'd2:    prefix_char = 8'h2B;
      5'd3:    prefix_char = 8'h42;
      5'd4:    prefix_char = 8'h4C;
      5'd5:    prefix_char = 8'h45;
      5'd6:    prefix_char = 8'h55;
      5'd7:    prefix_char = 8'h41;
      5'd8:    prefix_char = 8'h52;
      5'd9:    prefix_char = 8'h54;
      5'd10:   prefix_char = 8'h54;
      5'd11:   prefix_char = 8'h58;
      5'd12:   prefix_char = 8'h3D;
      default: prefix_char = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    hex_char = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign handshake = out_valid && out_ready;

  always_comb begin
    state_n = state;
    idx_n   = idx;
    data_n  = data_q;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          state_n = PREFIX;
          idx_n   = '0;
          data_n  = in_data;
        end
      end
      PREFIX: begin
        if (handshake) begin
          if (idx == 5'(PREFIX_LEN - 1)) begin
            state_n = PAYLOAD;
            idx_n   = '0;
          end else begin
            idx_n = idx + 5'd1;
          end
        end
      end
      PAYLOAD: begin
        if (handshake) begin
          // The word is shifted so the nibble being sent is always the top one.
          data_n = data_q << 4;
          if (idx == 5'(NIBBLES - 1)) begin
            state_n = (APPEND_CRLF != 0) ? TERM : IDLE;
            idx_n   = '0;
          end else begin
            idx_n = idx + 5'd1;
          end
        end
      end
      TERM: begin
        if (handshake) begin
          if (idx == 5'd1) begin
            state_n = IDLE;
            idx_n   = '0;
          end else begin
            idx_n = 5'd1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        idx_n   = '0;
      end
    endcase

    // Output byte is precomputed from the next state so the outputs are registered.
    byte_n = 8'h00;
    last_n = 1'b0;
    case (state_n)
      PREFIX:  byte_n = prefix_char(idx_n);
      PAYLOAD: begin
        byte_n = hex_char(data_n[DATA_WIDTH-1 -: 4]);
        last_n = (APPEND_CRLF == 0) && (idx_n == 5'(NIBBLES - 1));
      end
      TERM: begin
        byte_n = (idx_n == 5'd0) ? 8'h0D : 8'h0A;
        last_n = (idx_n == 5'd1);
      end
      default: begin
        byte_n = 8'h00;
        last_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      idx         <= '0;
      data_q      <= '0;
      out_valid   <= 1'b0;
      out_byte    <= 8'h00;
      out_last    <= 1'b0;
      frame_count <= '0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      data_q    <= data_n;
      out_valid <= (state_n != IDLE);
      out_byte  <= byte_n;
      out_last  <= last_n;
      if (handshake && out_last) begin
        frame_count <= frame_count + 1'b1;
      end
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_bluetooth_tx_framer.sv
// Directed bench for bluetooth_tx_framer: three instances cover the 32-bit CRLF,
// 8-bit no-CRLF and 2-bit counter configurations.
module tb_bluetooth_tx_framer;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  // Instance a: 32-bit payload, CR LF appended, 16-bit counter
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last, a_busy;
  logic [31:0] a_in_data;
  logic [7:0]  a_out_byte;
  logic [15:0] a_frame_count;
  logic [1:0]  a_state;
  logic [15:0] exp_count_a = 16'd0;

  bluetooth_tx_framer #(.DATA_WIDTH(32), .APPEND_CRLF(1), .COUNT_WIDTH(16)) u_a (
    .clk(clk), .reset_n(reset_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_byte(a_out_byte), .out_last(a_out_last), .busy(a_busy),
    .frame_count(a_frame_count), .dbg_state(a_state)
  );

  // Instance b: 8-bit payload, no CR LF
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_busy;
  logic [7:0]  b_in_data;
  logic [7:0]  b_out_byte;
  logic [15:0] b_frame_count;
  logic [1:0]  b_state;

  bluetooth_tx_framer #(.DATA_WIDTH(8), .APPEND_CRLF(0), .COUNT_WIDTH(16)) u_b (
    .clk(clk), .reset_n(reset_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_byte(b_out_byte), .out_last(b_out_last), .busy(b_busy),
    .frame_count(b_frame_count), .dbg_state(b_state)
  );

  // Instance c: 2-bit wrapping counter
  logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_last, c_busy;
  logic [31:0] c_in_data;
  logic [7:0]  c_out_byte;
  logic [1:0]  c_frame_count;
  logic [1:0]  c_state;

  bluetooth_tx_framer #(.DATA_WIDTH(32), .APPEND_CRLF(1), .COUNT_WIDTH(2)) u_c (
    .clk(clk), .reset_n(reset_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_byte(c_out_byte), .out_last(c_out_last), .busy(c_busy),
    .frame_count(c_frame_count), .dbg_state(c_state)
  );

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  task automatic push_crlf();
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // Called at a negedge while idle; returns at the negedge after the accept edge.
  task automatic send_a(input logic [31:0] word);
    checks++;
    if (a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_a_in_ready: got %b expected 1", a_in_ready);
    end
    a_in_valid = 1'b1;
    a_in_data  = word;
    @(negedge clk);
    a_in_valid = 1'b0;
    a_in_data  = ~word;
  endtask

  // Drains exp_q from instance a, checking bytes, out_last, stall stability and status.
  task automatic collect_a(input bit stall, input int frame_len);
    int cyc = 0;
    bit prev_stall = 1'b0;
    logic [7:0] prev_b = 8'h00;
    logic prev_l = 1'b0;
    logic [7:0] e;
    while (exp_q.size() > 0 && cyc < 400) begin
      a_out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      checks++;
      if ({a_out_valid, a_in_ready, a_busy} !== 3'b101) begin
        errors++;
        $display("FAIL a_status cyc %0d: got valid/in_ready/busy=%b expected 101", cyc,
                 {a_out_valid, a_in_ready, a_busy});
      end
      if (prev_stall) begin
        checks++;
        if (a_out_byte !== prev_b || a_out_last !== prev_l) begin
          errors++;
          $display("FAIL a_stall_stable cyc %0d: got %h/%b expected %h/%b", cyc,
                   a_out_byte, a_out_last, prev_b, prev_l);
        end
      end
      if (a_out_valid && a_out_ready) begin
        e = exp_q.pop_front();
        checks++;
        if (a_out_byte !== e) begin
          errors++;
          $display("FAIL a_byte cyc %0d: got %h expected %h", cyc, a_out_byte, e);
        end
        checks++;
        if (a_out_last !== (exp_q.size() == 0)) begin
          errors++;
          $display("FAIL a_last cyc %0d: got %b expected %b", cyc, a_out_last, exp_q.size() == 0);
        end
        prev_stall = 1'b0;
      end else begin
        prev_stall = a_out_valid;
        prev_b     = a_out_byte;
        prev_l     = a_out_last;
      end
      cyc++;
      @(negedge clk);
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL a_timeout: %0d bytes missing expected 0", exp_q.size());
      exp_q.delete();
    end
    exp_count_a = exp_count_a + 16'd1;
    if (!stall) begin
      checks++;
      if (cyc != frame_len) begin
        errors++;
        $display("FAIL a_frame_cycles: got %0d expected %0d", cyc, frame_len);
      end
    end
    checks++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_frame_count !== exp_count_a) begin
      errors++;
      $display("FAIL a_frame_end: got in_ready=%b out_valid=%b count=%0d expected 1 0 %0d",
               a_in_ready, a_out_valid, a_frame_count, exp_count_a);
    end
    a_out_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
    c_in_valid = 1'b0; c_in_data = '0; c_out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({a_in_ready, a_out_valid, a_out_byte, a_out_last, a_busy, a_frame_count, a_state}
        !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 2'b00}) begin
      errors++;
      $display("FAIL reset_a: got rdy=%b v=%b byte=%h last=%b busy=%b cnt=%0d st=%0d",
               a_in_ready, a_out_valid, a_out_byte, a_out_last, a_busy, a_frame_count, a_state);
    end
    checks++;
    if ({b_in_ready, b_out_valid, b_out_byte, b_out_last, b_busy, b_frame_count}
        !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000}) begin
      errors++;
      $display("FAIL reset_b: got rdy=%b v=%b byte=%h last=%b busy=%b cnt=%0d",
               b_in_ready, b_out_valid, b_out_byte, b_out_last, b_busy, b_frame_count);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_frame();
    send_a(32'h1234ABCD);
    checks++;
    if (a_out_byte !== 8'h41 || a_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL first_byte_latency: got v=%b byte=%h expected 1 41", a_out_valid, a_out_byte);
    end
    push_str("AT+BLEUARTTX=");
    push_str("1234ABCD");
    push_crlf();
    collect_a(1'b0, 23);
  endtask

  task automatic test_backpressure();
    send_a(32'h1234ABCD);
    push_str("AT+BLEUARTTX=");
    push_str("1234ABCD");
    push_crlf();
    collect_a(1'b1, 23);
  endtask

  task automatic test_short_frame();
    int cyc = 0;
    logic [7:0] e;
    push_str("AT+BLEUARTTX=");
    push_str("0F");
    b_in_valid = 1'b1;
    b_in_data  = 8'h0F;
    @(negedge clk);
    b_in_valid = 1'b0;
    b_in_data  = 8'hA5;
    while (exp_q.size() > 0 && cyc < 100) begin
      if (b_out_valid && b_out_ready) begin
        e = exp_q.pop_front();
        checks++;
        if (b_out_byte !== e || b_out_last !== (exp_q.size() == 0)) begin
          errors++;
          $display("FAIL b_byte cyc %0d: got %h/%b expected %h/%b", cyc, b_out_byte,
                   b_out_last, e, exp_q.size() == 0);
        end
      end
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0 || cyc != 15) begin
      errors++;
      $display("FAIL b_frame_len: got %0d cycles with %0d left expected 15 with 0", cyc, exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (b_frame_count !== 16'd1 || b_in_ready !== 1'b1 || b_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b_frame_end: got cnt=%0d rdy=%b v=%b expected 1 1 0",
               b_frame_count, b_in_ready, b_out_valid);
    end
  endtask

  task automatic test_hold_valid();
    a_in_valid = 1'b1;
    a_in_data  = 32'h00000000;
    @(negedge clk);
    a_in_data  = 32'hFFFFFFFF;
    push_str("AT+BLEUARTTX=");
    push_str("00000000");
    push_crlf();
    collect_a(1'b0, 23);
    @(negedge clk);
    a_in_valid = 1'b0;
    push_str("AT+BLEUARTTX=");
    push_str("FFFFFFFF");
    push_crlf();
    collect_a(1'b0, 23);
  endtask

  task automatic test_reset_mid_frame();
    send_a(32'hDEADBEEF);
    repeat (15) @(negedge clk);
    checks++;
    if (a_out_byte !== 8'h41) begin
      errors++;
      $display("FAIL mid_frame_byte15: got %h expected 41", a_out_byte);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (a_out_valid !== 1'b0 || a_frame_count !== 16'd0 || a_busy !== 1'b0 || a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: got v=%b cnt=%0d busy=%b rdy=%b expected 0 0 0 1",
               a_out_valid, a_frame_count, a_busy, a_in_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_frame_count !== 16'd0) begin
      errors++;
      $display("FAIL after_release: got rdy=%b v=%b cnt=%0d expected 1 0 0",
               a_in_ready, a_out_valid, a_frame_count);
    end
    exp_count_a = 16'd0;
    send_a(32'h1234ABCD);
    push_str("AT+BLEUARTTX=");
    push_str("1234ABCD");
    push_crlf();
    collect_a(1'b0, 23);
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_cnt[4];
    exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3; exp_cnt[3] = 2'd0;
    c_out_ready = 1'b1;
    c_in_data   = 32'h0BADF00D;
    c_in_valid  = 1'b1;
    for (int f = 0; f < 4; f++) begin
      int cyc = 0;
      while (!(c_out_valid && c_out_last) && cyc < 100) begin
        cyc++;
        @(negedge clk);
      end
      checks++;
      if (c_out_byte !== 8'h0A) begin
        errors++;
        $display("FAIL c_last_byte frame %0d: got %h expected 0a", f, c_out_byte);
      end
      @(negedge clk);
      if (f == 3) c_in_valid = 1'b0;
      checks++;
      if (c_frame_count !== exp_cnt[f]) begin
        errors++;
        $display("FAIL c_count frame %0d: got %0d expected %0d", f, c_frame_count, exp_cnt[f]);
      end
    end
    repeat (2) @(negedge clk);
    checks++;
    if (c_busy !== 1'b0 || c_frame_count !== 2'd0) begin
      errors++;
      $display("FAIL c_idle_after: got busy=%b cnt=%0d expected 0 0", c_busy, c_frame_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_short_frame();
    test_hold_valid();
    test_reset_mid_frame();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
